// File: rtl/crc_frame_parser.sv
// Splits a SOF/LEN/payload/CRC byte stream into a count stream (LEN) and a data stream (payload + CRC).
// Optional statistics counters (frame_cnt, drop_cnt) are built when CRC_PARSER_STATS_EN is defined.
module crc_frame_parser #(
    parameter logic [7:0]  SOF_BYTE = 8'h7E,
    parameter int unsigned MAX_LEN  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        cnt_valid,
    input  logic        cnt_ready,
    output logic [7:0]  cnt_data,
    output logic        d_valid,
    input  logic        d_ready,
    output logic [7:0]  d_data,
    output logic        err_len,
    output logic        frame_done
`ifdef CRC_PARSER_STATS_EN
    ,
    output logic [15:0] frame_cnt,
    output logic [15:0] drop_cnt
`endif
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_HUNT,
        S_LEN,
        S_CNT,
        S_PAY,
        S_CRC,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic       cnt_valid_q, cnt_valid_d;
    logic [7:0] cnt_data_q, cnt_data_d;
    logic       d_valid_q, d_valid_d;
    logic [7:0] d_data_q, d_data_d;
    logic [7:0] remaining_q, remaining_d;
    logic       err_len_q, err_len_d;
    logic       frame_done_q, frame_done_d;
    logic       d_slot_free;
    logic       d_drain;

    always_comb begin
        state_d      = state_q;
        cnt_valid_d  = cnt_valid_q;
        cnt_data_d   = cnt_data_q;
        d_valid_d    = d_valid_q;
        d_data_d     = d_data_q;
        remaining_d  = remaining_q;
        err_len_d    = 1'b0;
        frame_done_d = 1'b0;
        in_ready     = 1'b0;

        d_slot_free = !d_valid_q || d_ready;
        d_drain     = d_valid_q && d_ready;

        // A drained beat clears valid; a same-cycle load below sets it again.
        if (d_drain) begin
            d_valid_d = 1'b0;
        end

        case (state_q)
            S_HUNT: begin
                in_ready = 1'b1;
                if (in_valid && (in_data == SOF_BYTE)) begin
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_data > MAX_LEN_B) begin
                        err_len_d = 1'b1;
                        state_d   = S_HUNT;
                    end else begin
                        cnt_data_d  = in_data;
                        cnt_valid_d = 1'b1;
                        remaining_d = in_data;
                        state_d     = S_CNT;
                    end
                end
            end
            S_CNT: begin
                if (cnt_valid_q && cnt_ready) begin
                    cnt_valid_d = 1'b0;
                    state_d     = (remaining_q == '0) ? S_CRC : S_PAY;
                end
            end
            S_PAY: begin
                in_ready = d_slot_free;
                if (in_valid && d_slot_free) begin
                    d_data_d  = in_data;
                    d_valid_d = 1'b1;
                    if (remaining_q != '0) begin
                        remaining_d = remaining_q - 8'd1;
                    end
                    if (remaining_q == 8'd1) begin
                        state_d = S_CRC;
                    end
                end
            end
            S_CRC: begin
                in_ready = d_slot_free;
                if (in_valid && d_slot_free) begin
                    d_data_d  = in_data;
                    d_valid_d = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                if (d_drain) begin
                    frame_done_d = 1'b1;
                    state_d      = S_HUNT;
                end
            end
            default: begin
                state_d = S_HUNT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_HUNT;
            cnt_valid_q  <= 1'b0;
            cnt_data_q   <= '0;
            d_valid_q    <= 1'b0;
            d_data_q     <= '0;
            remaining_q  <= '0;
            err_len_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_valid_q  <= cnt_valid_d;
            cnt_data_q   <= cnt_data_d;
            d_valid_q    <= d_valid_d;
            d_data_q     <= d_data_d;
            remaining_q  <= remaining_d;
            err_len_q    <= err_len_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign cnt_valid  = cnt_valid_q;
    assign cnt_data   = cnt_data_q;
    assign d_valid    = d_valid_q;
    assign d_data     = d_data_q;
    assign err_len    = err_len_q;
    assign frame_done = frame_done_q;

`ifdef CRC_PARSER_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Counters follow the registered pulses and saturate rather than wrap.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (frame_done_q && (frame_cnt_q != '1)) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
        if (err_len_q && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;
`endif

endmodule
